fast_ctrl_sequencer: RTL

//  Parametrised fast-control generator for the ngCCM emulator; supersedes the per-mode fast_controls instances.

---
 rtl/fast_ctrl_sequencer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/fast_ctrl_sequencer.sv
// Fast-control sequencer for the ngCCM emulator: BX orbit counter, WTE / QIE-reset pulses, orbit lock, stretched reset.
// Optional macro FCS_ORBIT_MON_EN enables the saturating orbit error counter.
module fast_ctrl_sequencer #(
    parameter int N_CH      = 4,
    parameter int ORBIT_LEN = 3564,
    parameter int CNT_W     = 12,
    parameter int WTE_BX    = 3500,
    parameter int QRST_BX   = 3563,
    parameter int RST_LEN   = 40
) (
    input  logic             clk_in,
    input  logic             reset_in,
    input  logic             mode_sel,
    input  logic             wte_in_n,
    input  logic             qie_reset_in_n,
    input  logic             reset_switch,
    input  logic [N_CH-1:0]  ch_enable,
    output logic [N_CH-1:0]  wte_out,
    output logic [N_CH-1:0]  qie_reset_out,
    output logic             reset_out,
    output logic [CNT_W-1:0] bx_count,
    output logic             orbit_lock,
    output logic [7:0]       orbit_err_cnt
);

    typedef enum logic [1:0] {
        S_INT   = 2'd0,
        S_ACQ   = 2'd1,
        S_TRACK = 2'd2,
        S_LOCK  = 2'd3
    } state_t;

    localparam int RC_W = (RST_LEN > 1) ? $clog2(RST_LEN) : 1;
    localparam logic [CNT_W-1:0] L_LAST  = CNT_W'(ORBIT_LEN - 1);
    localparam logic [CNT_W-1:0] L_WTE   = CNT_W'(WTE_BX);
    localparam logic [CNT_W-1:0] L_QRST  = CNT_W'(QRST_BX);
    localparam logic [RC_W-1:0]  L_RLOAD = RC_W'(RST_LEN - 1);

    // bit0/bit1 are the synchroniser, bit2 is the edge-detect history
    logic [2:0]      r_wte_sync;
    logic [2:0]      r_qrst_sync;
    logic [2:0]      r_rsw_sync;
    logic [2:0]      r_mode_sync;
    state_t          r_state;
    logic [CNT_W-1:0] r_bx;
    logic [RC_W-1:0] r_rst_cnt;
    logic            r_reset_out;
    logic            r_lock;
    logic [N_CH-1:0] r_wte_out;
    logic [N_CH-1:0] r_qrst_out;

    logic w_mode_int;
    logic w_mode_chg;
    logic w_ext_wte;
    logic w_ext_qrst;
    logic w_rsw_rise;
    logic w_bx_last;
    logic w_wte_pulse;
    logic w_qrst_pulse;

    assign w_mode_int   = r_mode_sync[1];
    assign w_mode_chg   = r_mode_sync[1] ^ r_mode_sync[2];
    assign w_ext_wte    = r_wte_sync[2] & ~r_wte_sync[1];
    assign w_ext_qrst   = r_qrst_sync[2] & ~r_qrst_sync[1] & ~w_mode_int & ~w_mode_chg;
    assign w_rsw_rise   = r_rsw_sync[1] & ~r_rsw_sync[2];
    assign w_bx_last    = (r_bx == L_LAST);
    assign w_wte_pulse  = ~w_mode_chg & (w_mode_int ? (r_bx == L_WTE)  : w_ext_wte);
    assign w_qrst_pulse = ~w_mode_chg & (w_mode_int ? (r_bx == L_QRST) : w_ext_qrst);

    // Input synchronisers with edge history
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_wte_sync  <= 3'b111;
            r_qrst_sync <= 3'b111;
            r_rsw_sync  <= 3'b000;
            r_mode_sync <= 3'b000;
        end else begin
            r_wte_sync  <= {r_wte_sync[1:0], wte_in_n};
            r_qrst_sync <= {r_qrst_sync[1:0], qie_reset_in_n};
            r_rsw_sync  <= {r_rsw_sync[1:0], reset_switch};
            r_mode_sync <= {r_mode_sync[1:0], mode_sel};
        end
    end

    // Per-channel gated pulse outputs
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_wte_out  <= {N_CH{1'b0}};
            r_qrst_out <= {N_CH{1'b0}};
        end else begin
            r_wte_out  <= {N_CH{w_wte_pulse}} & ch_enable;
            r_qrst_out <= {N_CH{w_qrst_pulse}} & ch_enable;
        end
    end

    // BX counter; an external QIE reset realigns it to zero
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_bx <= {CNT_W{1'b0}};
        end else if (w_mode_chg || w_ext_qrst || w_bx_last) begin
            r_bx <= {CNT_W{1'b0}};
        end else begin
            r_bx <= r_bx + CNT_W'(1);
        end
    end

    // Orbit tracking FSM with registered lock flag
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_state <= S_ACQ;
            r_lock  <= 1'b0;
        end else if (w_mode_chg) begin
            r_state <= w_mode_int ? S_INT : S_ACQ;
            r_lock  <= w_mode_int;
        end else begin
            case (r_state)
                S_INT: begin
                    r_state <= S_INT;
                    r_lock  <= 1'b1;
                end
                S_ACQ: begin
                    r_state <= w_ext_qrst ? S_TRACK : S_ACQ;
                    r_lock  <= 1'b0;
                end
                S_TRACK, S_LOCK: begin
                    if (w_ext_qrst && w_bx_last) begin
                        r_state <= S_LOCK;
                        r_lock  <= 1'b1;
                    end else if (w_ext_qrst) begin
                        r_state <= S_TRACK;
                        r_lock  <= 1'b0;
                    end else if (w_bx_last) begin
                        r_state <= S_ACQ;
                        r_lock  <= 1'b0;
                    end else begin
                        r_state <= r_state;
                        r_lock  <= (r_state == S_LOCK);
                    end
                end
                default: begin
                    r_state <= S_ACQ;
                    r_lock  <= 1'b0;
                end
            endcase
        end
    end

    // Reset stretcher; a new request reloads the full length
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_rst_cnt   <= {RC_W{1'b0}};
            r_reset_out <= 1'b0;
        end else if (w_rsw_rise) begin
            r_rst_cnt   <= L_RLOAD;
            r_reset_out <= 1'b1;
        end else if (r_rst_cnt != {RC_W{1'b0}}) begin
            r_rst_cnt   <= r_rst_cnt - RC_W'(1);
            r_reset_out <= 1'b1;
        end else begin
            r_rst_cnt   <= {RC_W{1'b0}};
            r_reset_out <= 1'b0;
        end
    end

`ifdef FCS_ORBIT_MON_EN
    logic       w_err;
    logic [7:0] r_err_cnt;

    // misaligned and missing QIE resets are exactly the cases where qrst and wrap disagree
    assign w_err = ~w_mode_chg & ~w_mode_int & ((r_state == S_TRACK) | (r_state == S_LOCK))
                 & (w_ext_qrst ^ w_bx_last);

    // Saturating orbit error counter
    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            r_err_cnt <= 8'd0;
        end else if (w_mode_chg) begin
            r_err_cnt <= 8'd0;
        end else if (w_err && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end else begin
            r_err_cnt <= r_err_cnt;
        end
    end

    assign orbit_err_cnt = r_err_cnt;
`else
    assign orbit_err_cnt = 8'd0;
`endif

    assign wte_out       = r_wte_out;
    assign qie_reset_out = r_qrst_out;
    assign reset_out     = r_reset_out;
    assign bx_count      = r_bx;
    assign orbit_lock    = r_lock;

endmodule
